// File: rtl/bmc_soft_pipe.sv
// Two-stage soft-decision branch metric unit: per-symbol distances, then 2^N code-word sums.
// Optional depuncturing with a rotating erasure pattern is compiled in by BMC_PUNCTURE_EN.
module bmc_soft_pipe #(
  parameter int unsigned             N         = 2,
  parameter int unsigned             Q         = 3,
  parameter int unsigned             PUNCT_LEN = 3,
  parameter logic [N*PUNCT_LEN-1:0]  PUNCT_PAT = 6'b011011,
  localparam int unsigned            MW        = Q + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sync,
  input  logic [N*Q-1:0]          in_sym,
  output logic                    out_valid,
  output logic [(2**N)*MW-1:0]    bm_out,
  output logic [N-1:0]            out_erase
);

  localparam int unsigned NC     = 1 << N;
  localparam logic [Q-1:0] SymMax = '1;

  logic [N-1:0]          erase_d;
  logic [N-1:0][Q-1:0]   sym;
  logic [N-1:0][Q-1:0]   d0_d, d1_d;
  logic [N-1:0][Q-1:0]   d0_q, d1_q;
  logic [N-1:0]          erase1_q;
  logic                  v1_q;
  logic [NC-1:0][MW-1:0] sum_d;

  assign sym = in_sym;

`ifdef BMC_PUNCTURE_EN
  localparam int unsigned PW = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1;
  localparam logic [PW-1:0] LastPhase = PW'(PUNCT_LEN - 1);

  logic [PW-1:0] phase_q, phase_d, cur_phase;
  logic [N-1:0]  pat [PUNCT_LEN];

  for (genvar k = 0; k < PUNCT_LEN; k++) begin : g_pat
    assign pat[k] = PUNCT_PAT[N*k +: N];
  end

  // in_sync restarts the pattern on this very branch, overriding any wrap.
  always_comb begin
    cur_phase = in_sync ? '0 : phase_q;
    erase_d   = ~pat[cur_phase];
    phase_d   = phase_q;
    if (in_valid) begin
      phase_d = (cur_phase == LastPhase) ? '0 : cur_phase + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{in_sync, PUNCT_PAT, PUNCT_LEN};
  assign erase_d    = '0;
`endif

  // Erased symbols contribute nothing to either hypothesis.
  always_comb begin
    d0_d = '0;
    d1_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!erase_d[i]) begin
        d0_d[i] = sym[i];
        d1_d[i] = SymMax - sym[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      erase1_q <= '0;
      d0_q     <= '0;
      d1_q     <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        erase1_q <= erase_d;
        d0_q     <= d0_d;
        d1_q     <= d1_d;
      end
    end
  end

  // Worst case N*(2^Q-1) fits in MW bits, so plain wrapping adds are exact.
  always_comb begin
    sum_d = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (((c >> i) & 1) == 1) begin
          sum_d[c] = sum_d[c] + MW'(d1_q[i]);
        end else begin
          sum_d[c] = sum_d[c] + MW'(d0_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bm_out    <= '0;
      out_erase <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        bm_out    <= sum_d;
        out_erase <= erase1_q;
      end
    end
  end

endmodule
